// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO stream reader: FSM encodings and the
// buffer occupancy helper used to throttle FIFO reads.
package fifo_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] RUN   = 2'd1;
  localparam logic [STATE_W-1:0] FLUSH = 2'd2;
  localparam logic [STATE_W-1:0] DONE  = 2'd3;

  // Beats that will occupy the output buffer after this edge: stored + arriving - leaving.
  function automatic logic [2:0] occupancy(input logic [1:0] cnt,
                                           input logic       inflight,
                                           input logic       pop);
    return {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer; entry 0 is always the oldest beat and
// is what the stream side sees, so it only moves on a pop.
module fifo_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_capture,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem0;
  logic [DATA_WIDTH-1:0] r_mem1;
  logic [1:0]            r_cnt;

  // Storage and count update; caller guarantees no pop when empty and no capture when full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= 2'd0;
      r_mem0 <= {DATA_WIDTH{1'b0}};
      r_mem1 <= {DATA_WIDTH{1'b0}};
    end else begin
      case ({i_capture, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_data;
          else               r_mem1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem0;
  assign o_count = r_cnt;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a burst of len beats from a registered-output FIFO and streams them
// out with valid/ready. Optional stall counter: FIFO_STREAM_READER_STALL_CNT_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [STATE_W-1:0]   r_state;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_inflight;
  logic                 w_pop;
  logic                 w_rd_en;
  logic [1:0]           w_buf_cnt;

  assign w_pop = m_valid & m_ready;

  // Read only while the buffer can absorb every beat already committed to it.
  always_comb begin
    w_rd_en = 1'b0;
    if (rst && (r_state == RUN) && !fifo_empty && (r_remaining != LEN_ZERO) &&
        (occupancy(w_buf_cnt, r_inflight, w_pop) < 3'd2)) begin
      w_rd_en = 1'b1;
    end else begin
      w_rd_en = 1'b0;
    end
  end

  assign fifo_r_en = w_rd_en;

  // Burst sequencing and remaining-beat bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_remaining <= LEN_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len != LEN_ZERO) begin
              r_state     <= RUN;
              r_remaining <= len;
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (w_rd_en) begin
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!r_inflight && (w_buf_cnt == 2'd0)) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A read issued this cycle delivers its data next cycle.
  always_ff @(posedge clk) begin
    if (!rst) r_inflight <= 1'b0;
    else      r_inflight <= w_rd_en;
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_capture (r_inflight),
    .i_pop     (w_pop),
    .i_data    (fifo_data),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_count   (w_buf_cnt)
  );

  assign busy = (r_state == RUN) || (r_state == FLUSH);
  assign done = (r_state == DONE);

`ifdef FIFO_STREAM_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the downstream holds off a valid beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= 16'd0;
    end else if (m_valid && !m_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a registered-output FIFO model.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  // FIFO model
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       force_empty = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // Monitor, sampled on the falling edge
  int cyc = 0;
  int ren_cnt = 0;
  int ren_empty = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ren_q[$];
  logic [7:0] rx[$];
  int rx_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_r_en) begin
      ren_cnt = ren_cnt + 1;
      ren_q.push_back(cyc);
      if (fifo_empty) ren_empty = ren_empty + 1;
    end
    if (m_valid && m_ready) begin
      rx.push_back(m_data);
      rx_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = first + 8'(i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic fifo_clear;
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic wait_done;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: got no done pulse, required one within 300 cycles");
    end
  endtask

  task automatic check_beats(input string name, input int base, input int n, input logic [7:0] first);
    checks++;
    if (rx.size() - base !== n) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, rx.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx[base+i] !== first + 8'(i)) begin
          errors++;
          $display("FAIL %s_beat%0d: got %h, required %h", name, i, rx[base+i], first + 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset;
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b, required 0", m_valid); end
    if (m_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h, required 00", m_data); end
    if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b, required 0", fifo_r_en); end
  endtask

  task automatic test_stream;
    int br = rx.size();
    int bren = ren_q.size();
    int bd = done_cnt;
    fifo_clear();
    load(4, 8'h01);
    m_ready = 1'b1;
    pulse_start(8'd4);
    wait_done();
    tick();
    tick();
    check_beats("stream", br, 4, 8'h01);
    if (rx.size() - br == 4 && ren_q.size() > bren) begin
      checks += 3;
      if (rx_cyc[br+3] - rx_cyc[br] !== 3) begin
        errors++; $display("FAIL stream_consecutive: got span %0d, required 3", rx_cyc[br+3] - rx_cyc[br]);
      end
      if (rx_cyc[br] - ren_q[bren] !== 2) begin
        errors++; $display("FAIL stream_latency: got %0d, required 2", rx_cyc[br] - ren_q[bren]);
      end
      if (done_cyc - rx_cyc[br+3] !== 2) begin
        errors++; $display("FAIL stream_done_delay: got %0d, required 2", done_cyc - rx_cyc[br+3]);
      end
    end
    checks += 2;
    if (done_cnt - bd !== 1) begin errors++; $display("FAIL stream_done_count: got %0d, required 1", done_cnt - bd); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL stream_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_backpressure;
    int br = rx.size();
    int bren = ren_cnt;
    bit seen = 1'b0;
    fifo_clear();
    load(6, 8'h01);
    m_ready = 1'b0;
    pulse_start(8'd6);
    for (int i = 0; i < 20; i++) begin
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_valid: got no m_valid, required within 20 cycles"); end
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b, required 1", k, m_valid); end
      if (m_data !== 8'h01) begin errors++; $display("FAIL bp_hold_data%0d: got %h, required 01", k, m_data); end
      tick();
    end
    checks++;
    if (ren_cnt - bren !== 2) begin errors++; $display("FAIL bp_reads: got %0d, required 2", ren_cnt - bren); end
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall_cnt: got %0d, required 5", stall_cnt); end
`endif
    m_ready = 1'b1;
    wait_done();
    tick();
    check_beats("bp", br, 6, 8'h01);
  endtask

  task automatic test_underflow;
    int br = rx.size();
    int bren = ren_cnt;
    int bre = ren_empty;
    fifo_clear();
    load(8, 8'h11);
    m_ready = 1'b1;
    pulse_start(8'd8);
    tick();
    tick();
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL uf_ren%0d: got %b, required 0", i, fifo_r_en); end
      tick();
    end
    force_empty = 1'b0;
    wait_done();
    tick();
    check_beats("uf", br, 8, 8'h11);
    checks += 2;
    if (ren_cnt - bren !== 8)  begin errors++; $display("FAIL uf_reads: got %0d, required 8", ren_cnt - bren); end
    if (ren_empty - bre !== 0) begin errors++; $display("FAIL uf_read_empty: got %0d, required 0", ren_empty - bre); end
  endtask

  task automatic test_len_zero;
    int bren = ren_cnt;
    fifo_clear();
    pulse_start(8'd0);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b, required 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b, required 0", busy); end
    tick();
    checks += 3;
    if (done !== 1'b0)        begin errors++; $display("FAIL len0_done_once: got %b, required 0", done); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL len0_busy2: got %b, required 0", busy); end
    if (ren_cnt - bren !== 0) begin errors++; $display("FAIL len0_reads: got %0d, required 0", ren_cnt - bren); end
  endtask

  task automatic test_ignore_start;
    int br = rx.size();
    int bren = ren_cnt;
    fifo_clear();
    load(3, 8'h21);
    load(9, 8'h40);
    m_ready = 1'b1;
    pulse_start(8'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b, required 1", busy); end
    pulse_start(8'd9);
    wait_done();
    tick();
    tick();
    check_beats("ign", br, 3, 8'h21);
    checks += 2;
    if (ren_cnt - bren !== 3) begin errors++; $display("FAIL ign_reads: got %0d, required 3", ren_cnt - bren); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL ign_restart: got %b, required 0", busy); end
    fifo_clear();
  endtask

  task automatic test_reset_mid;
    int bd;
    fifo_clear();
    load(8, 8'h31);
    m_ready = 1'b1;
    pulse_start(8'd8);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL rst_ren_low: got %b, required 0", fifo_r_en); end
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    fifo_clear();
    bd = done_cnt;
    for (int i = 0; i < 5; i++) tick();
    checks += 3;
    if (done_cnt !== bd) begin errors++; $display("FAIL rst_no_done: got %0d pulses, required 0", done_cnt - bd); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy_after: got %b, required 0", busy); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_after: got %b, required 0", m_valid); end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    len     = 8'd0;
    m_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_stream();
    test_backpressure();
    test_underflow();
    test_len_zero();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of FIFO data and stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of the burst length field.
REQ-003 SHALL have ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports:
- start  in  1  burst request pulse.
- len  in  LEN_WIDTH  number of beats in the burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.
REQ-005 SHALL have FIFO read-side ports:
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO read enable.
- fifo_data  in  DATA_WIDTH  FIFO registered read data.
REQ-006 SHALL have stream-side ports:
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output beat.

Function
REQ-007 SHALL treat fifo_data as valid in the cycle after a cycle in which fifo_r_en=1; that cycle is one "in flight" read.
REQ-008 SHALL assert fifo_r_en only when: state=RUN, fifo_empty=0, remaining>0, and (buf_cnt + inflight - pop) < 2, where pop = m_valid & m_ready; fifo_r_en is combinational.
REQ-009 SHALL capture fifo_data into a 2-entry output buffer at the clock edge ending each in-flight cycle; it SHALL never drop a beat and never overflow.
REQ-010 SHALL present m_valid=1 iff buf_cnt>0, with m_data = oldest entry; latency from fifo_r_en to m_valid is 2 cycles.
REQ-011 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-012 SHALL sustain 1 beat/cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-013 SHALL use FSM states IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start=1 with len!=0: load remaining=len.
- IDLE -> DONE on start=1 with len=0.
- RUN -> FLUSH when the last read is issued (remaining reaches 0).
- FLUSH -> DONE when inflight=0 and buf_cnt=0.
- DONE -> IDLE unconditionally.
REQ-014 SHALL drive busy=1 in RUN and FLUSH, and done=1 only in DONE.
REQ-015 SHALL ignore start while not in IDLE.
REQ-016 SHALL decrement remaining by 1 per fifo_r_en; remaining is LEN_WIDTH bits and never wraps below 0.
REQ-017 SHALL, when a capture and a pop occur in the same cycle, keep buf_cnt unchanged and preserve beat order.
REQ-018 SHALL stall reads while fifo_empty=1 and resume the cycle fifo_empty returns to 0, with no lost or duplicated beats.

Reset
REQ-019 SHALL on rst=0 at a clock edge set:
- state=IDLE, remaining=0, buf_cnt=0, inflight=0
- busy=0, done=0, m_valid=0, m_data=0
REQ-020 SHALL hold fifo_r_en=0 while rst=0.
REQ-021 SHALL discard all buffered and in-flight data on reset mid-burst; no done pulse is produced.

Configuration
REQ-022 SHALL, when FIFO_STREAM_READER_STALL_CNT_EN is defined, add output stall_cnt [15:0]:
- counts cycles with m_valid=1 and m_ready=0
- saturates at 16'hFFFF
- cleared to 0 on reset and on an accepted start
REQ-023 SHALL, when FIFO_STREAM_READER_STALL_CNT_EN is undefined, have no stall_cnt port or counter logic; all other behaviour is identical.

Structure
REQ-024 SHALL take the FSM state encodings (IDLE=0, RUN=1, FLUSH=2, DONE=3) and the state width constant from shared package fifo_pkg.
REQ-025 SHALL implement the 2-entry output buffer as sub-module fifo_skid_buf, with capture/pop inputs and valid/data/count outputs.

Verification
REQ-026 Reset: rst=0 for 2 cycles mid-burst -> the following cycle shows busy=0, m_valid=0, fifo_r_en=0, m_data=0.
REQ-027 Streaming: FIFO preloaded with 8'h01..8'h04, len=4, m_ready=1 -> beats 01,02,03,04 on 4 consecutive cycles.
- first m_valid 2 cycles after the first fifo_r_en
- done pulses once, 2 cycles after the last beat
REQ-028 Backpressure: len=6, m_ready=0 for 5 cycles then 1 -> fifo_r_en goes low after 2 reads.
- m_data holds 8'h01
- all 6 beats arrive in order
- stall_cnt=5 when the macro is defined
REQ-029 Underflow: fifo_empty=1 for 3 cycles mid-burst -> no fifo_r_en during those cycles; beat sequence continuous with no duplicates.
REQ-030 len=0 start -> done=1 exactly one cycle later; no fifo_r_en; busy stays 0.
REQ-031 start=1 pulsed while busy with len=9 -> ignored; the original burst completes with its own length.
